// File: rtl/firefly_pkg.sv
// Shared types and helpers for the firefly period follower.
package firefly_pkg;

  typedef enum logic [1:0] {IDLE, LEARN, READY, FOLLOW} state_e;

  localparam int unsigned MAX_W = 32;

  // Largest value a w-bit period counter can hold before it saturates.
  function automatic logic [MAX_W-1:0] cnt_sat(input int unsigned w);
    return (MAX_W'(1) << w) - MAX_W'(1);
  endfunction

  // High time in cycles for a given period and duty; a nonzero duty never rounds down to zero.
  function automatic logic [MAX_W-1:0] calc_hi(input logic [MAX_W-1:0] per,
                                               input logic [MAX_W-1:0] duty,
                                               input int unsigned      duty_w);
    logic [2*MAX_W-1:0] prod;
    prod = (2*MAX_W)'(per) * (2*MAX_W)'(duty);
    prod = prod >> duty_w;
    if ((duty != '0) && (prod == '0)) begin
      prod = (2*MAX_W)'(1);
    end
    return MAX_W'(prod);
  endfunction

endpackage

// File: rtl/firefly_follower_edge_sync.sv
// Two-flop synchroniser followed by a registered rising-edge pulse.
module edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic level_o,
  output logic rise_o
);

  logic meta_q, sync_q, prev_q, rise_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = rise_q;

endmodule

// File: rtl/firefly_follower.sv
// Learns the averaged period of f0 and regenerates it on f1 with programmable duty.
// Define FIREFLY_PHASE_ALIGN_EN to realign the f1 phase to every f0 edge while following.
module firefly_follower
  import firefly_pkg::*;
#(
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned AVG_LOG2 = 2,
  parameter int unsigned DUTY_W   = 8,
  parameter int unsigned MIN_PER  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              f0,
  input  logic              learn,
  input  logic              start,
  input  logic [DUTY_W-1:0] duty,
  output logic              f1,
  output logic [CNT_W-1:0]  period,
  output logic              locked,
  output logic              err
);

  localparam int unsigned      ACC_W     = CNT_W + AVG_LOG2;
  localparam int unsigned      NPER_W    = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] SAT       = CNT_W'(cnt_sat(CNT_W));
  localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PER);
  localparam logic [NPER_W-1:0] NPER_LAST = NPER_W'((1 << AVG_LOG2) - 1);

  logic f0_rise, f0_level_unused, learn_rise, learn_lvl;

  edge_sync u_f0_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (f0),
    .level_o (f0_level_unused),
    .rise_o  (f0_rise)
  );

  edge_sync u_learn_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .d_i     (learn),
    .level_o (learn_lvl),
    .rise_o  (learn_rise)
  );

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [NPER_W-1:0]  nper_q, nper_d;
  logic               armed_q, armed_d;
  logic [CNT_W-1:0]   period_q, period_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic               f1_q, f1_d;
  logic [CNT_W-1:0]   phase_q, phase_d;
  logic [CNT_W-1:0]   hi_q, hi_d;

  logic [ACC_W-1:0]   acc_sum;
  logic [CNT_W-1:0]   avg, hi_new, phase_nx;
  logic               wrap;

  assign acc_sum  = acc_q + ACC_W'(cnt_q);
  assign avg      = CNT_W'(acc_sum >> AVG_LOG2);
  assign hi_new   = CNT_W'(calc_hi(MAX_W'(period_q), MAX_W'(duty), DUTY_W));
  assign phase_nx = phase_q + CNT_W'(1);
  assign wrap     = (phase_nx == period_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      nper_q   <= '0;
      armed_q  <= 1'b0;
      period_q <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
      f1_q     <= 1'b0;
      phase_q  <= '0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      nper_q   <= nper_d;
      armed_q  <= armed_d;
      period_q <= period_d;
      locked_q <= locked_d;
      err_q    <= err_d;
      f1_q     <= f1_d;
      phase_q  <= phase_d;
      hi_q     <= hi_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    nper_d   = nper_q;
    armed_d  = armed_q;
    period_d = period_q;
    locked_d = locked_q;
    err_d    = err_q;
    f1_d     = f1_q;
    phase_d  = phase_q;
    hi_d     = hi_q;

    // A learn edge restarts learning from any state.
    if (learn_rise) begin
      state_d  = LEARN;
      locked_d = 1'b0;
      err_d    = 1'b0;
      f1_d     = 1'b0;
      cnt_d    = '0;
      acc_d    = '0;
      nper_d   = '0;
      armed_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: ;
        LEARN: begin
          if (!learn_lvl) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
            nper_d  = '0;
            armed_d = 1'b0;
          end else if (f0_rise) begin
            // An edge beats a coincident saturation: its count is accepted.
            cnt_d = CNT_W'(1);
            if (!armed_q) begin
              armed_d = 1'b1;
            end else if (nper_q == NPER_LAST) begin
              cnt_d   = '0;
              acc_d   = '0;
              nper_d  = '0;
              armed_d = 1'b0;
              if (avg >= MIN_P) begin
                period_d = avg;
                locked_d = 1'b1;
                state_d  = READY;
              end else begin
                err_d   = 1'b1;
                state_d = IDLE;
              end
            end else begin
              acc_d  = acc_sum;
              nper_d = nper_q + NPER_W'(1);
            end
          end else if (cnt_q == SAT) begin
            err_d    = 1'b1;
            locked_d = 1'b0;
            state_d  = IDLE;
            cnt_d    = '0;
            acc_d    = '0;
            nper_d   = '0;
            armed_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        READY: begin
          f1_d = 1'b0;
          if (start) begin
            state_d = FOLLOW;
            phase_d = '0;
            hi_d    = hi_new;
            f1_d    = (hi_new != '0);
          end
        end
        FOLLOW: begin
          if (!start) begin
            state_d = READY;
            f1_d    = 1'b0;
          end else begin
            if (wrap) begin
              phase_d = '0;
              hi_d    = hi_new;
              f1_d    = (hi_new != '0);
            end else begin
              phase_d = phase_nx;
              f1_d    = (phase_nx < hi_q);
            end
`ifdef FIREFLY_PHASE_ALIGN_EN
            if (f0_rise) begin
              phase_d = '0;
              hi_d    = hi_new;
              f1_d    = (hi_new != '0);
            end
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign f1     = f1_q;
  assign period = period_q;
  assign locked = locked_q;
  assign err    = err_q;

endmodule
